// File: rtl/interrupt_ack_control.sv
// interrupt_ack_control: INT request, two-pulse INTA acknowledge and
// OCW2 EOI/rotation sequencer for the 8259A in-service datapath.
module interrupt_ack_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] highestRequest,
  input  logic [7:0] highestInServ,
  input  logic       inta,
  input  logic       ocw2Strobe,
  input  logic [2:0] ocw2Cmd,
  input  logic [2:0] ocw2Level,
  input  logic       autoEoi,
  input  logic [4:0] vectorBase,
  output logic       intOut,
  output logic       inServSignal,
  output logic [7:0] interrupt,
  output logic [7:0] vectorOut,
  output logic       vectorValid,
  output logic [7:0] endOfInterrupt,
  output logic [2:0] priorityRotate
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } state_t;

  // lowest set bit wins if the input is ever not strictly one-hot
  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] e;
    e = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) e = 3'(i);
    end
    return e;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] l);
    return 8'd1 << l;
  endfunction

  // rank 0 is the level just above the lowest-priority level
  function automatic logic [2:0] rank(
    input logic [2:0] l,
    input logic [2:0] rot
  );
    return l - rot - 3'd1;
  endfunction

  state_t     state_q, state_d;
  logic       int_out_q, int_out_d;
  logic       in_serv_q, in_serv_d;
  logic [7:0] interrupt_q, interrupt_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_valid_q, vector_valid_d;
  logic [7:0] eoi_q, eoi_d;
  logic [2:0] rot_q, rot_d;
  logic       raeoi_q, raeoi_d;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;

  logic       req_any;
  logic       isv_any;
  logic [2:0] req_lvl;
  logic [2:0] isv_lvl;
  logic       req_wins;

  logic [7:0] aeoi_mask;
  logic       aeoi_rot_we;
  logic [7:0] ocw_mask;
  logic       ocw_rot_we;
  logic [2:0] ocw_rot_val;
  logic       ocw_raeoi_set;
  logic       ocw_raeoi_clr;

  // request versus in-service comparison under the current rotation
  always_comb begin
    req_any  = |highestRequest;
    isv_any  = |highestInServ;
    req_lvl  = enc8(highestRequest);
    isv_lvl  = enc8(highestInServ);
    req_wins = req_any &&
               (!isv_any ||
                (rank(req_lvl, rot_q) < rank(isv_lvl, rot_q)));
  end

  // acknowledge sequencer: IDLE raises INT, two INTA pulses finish it
  always_comb begin
    state_d        = state_q;
    int_out_d      = 1'b0;
    in_serv_d      = 1'b0;
    interrupt_d    = 8'd0;
    vector_out_d   = vector_out_q;
    vector_valid_d = 1'b0;
    ack_level_d    = ack_level_q;
    spurious_d     = spurious_q;
    aeoi_mask      = 8'd0;
    aeoi_rot_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inta) begin
          state_d    = ACK1;
          spurious_d = !req_any;
          if (req_any) begin
            ack_level_d = req_lvl;
            in_serv_d   = 1'b1;
            interrupt_d = onehot8(req_lvl);
          end else begin
            ack_level_d = 3'd7;
          end
        end else begin
          int_out_d = req_wins;
        end
      end
      ACK1: begin
        if (inta) begin
          state_d        = IDLE;
          vector_out_d   = {vectorBase, ack_level_q};
          vector_valid_d = 1'b1;
          if (autoEoi && !spurious_q) begin
            aeoi_mask   = onehot8(ack_level_q);
            aeoi_rot_we = raeoi_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // OCW2 command decode, honoured in either sequencer state
  always_comb begin
    ocw_mask      = 8'd0;
    ocw_rot_we    = 1'b0;
    ocw_rot_val   = ocw2Level;
    ocw_raeoi_set = 1'b0;
    ocw_raeoi_clr = 1'b0;
    if (ocw2Strobe) begin
      unique case (ocw2Cmd)
        3'b001: ocw_mask = highestInServ;
        3'b011: ocw_mask = onehot8(ocw2Level);
        3'b101: begin
          ocw_mask    = highestInServ;
          ocw_rot_we  = isv_any;
          ocw_rot_val = isv_lvl;
        end
        3'b111: begin
          ocw_mask   = onehot8(ocw2Level);
          ocw_rot_we = 1'b1;
        end
        3'b110: ocw_rot_we    = 1'b1;
        3'b100: ocw_raeoi_set = 1'b1;
        3'b000: ocw_raeoi_clr = 1'b1;
        default: ;
      endcase
    end
  end

  // merge AEOI and OCW2 effects; an OCW2 rotation beats the AEOI one
  always_comb begin
    eoi_d   = aeoi_mask | ocw_mask;
    rot_d   = rot_q;
    raeoi_d = raeoi_q;
    if (ocw_rot_we) begin
      rot_d = ocw_rot_val;
    end else if (aeoi_rot_we) begin
      rot_d = ack_level_q;
    end
    if (ocw_raeoi_set) begin
      raeoi_d = 1'b1;
    end else if (ocw_raeoi_clr) begin
      raeoi_d = 1'b0;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      int_out_q      <= 1'b0;
      in_serv_q      <= 1'b0;
      interrupt_q    <= 8'd0;
      vector_out_q   <= 8'd0;
      vector_valid_q <= 1'b0;
      eoi_q          <= 8'd0;
      rot_q          <= 3'b111;
      raeoi_q        <= 1'b0;
      ack_level_q    <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      int_out_q      <= int_out_d;
      in_serv_q      <= in_serv_d;
      interrupt_q    <= interrupt_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      eoi_q          <= eoi_d;
      rot_q          <= rot_d;
      raeoi_q        <= raeoi_d;
      ack_level_q    <= ack_level_d;
      spurious_q     <= spurious_d;
    end
  end

  assign intOut         = int_out_q;
  assign inServSignal   = in_serv_q;
  assign interrupt      = interrupt_q;
  assign vectorOut      = vector_out_q;
  assign vectorValid    = vector_valid_q;
  assign endOfInterrupt = eoi_q;
  assign priorityRotate = rot_q;

endmodule

// File: tb/tb_interrupt_ack_control.sv
// tb_interrupt_ack_control: directed plus random stimulus against a
// behavioural model of the 8259A acknowledge/EOI rules.
module tb_interrupt_ack_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] highestRequest;
  logic [7:0] highestInServ;
  logic       inta;
  logic       ocw2Strobe;
  logic [2:0] ocw2Cmd;
  logic [2:0] ocw2Level;
  logic       autoEoi;
  logic [4:0] vectorBase;
  logic       intOut;
  logic       inServSignal;
  logic [7:0] interrupt;
  logic [7:0] vectorOut;
  logic       vectorValid;
  logic [7:0] endOfInterrupt;
  logic [2:0] priorityRotate;

  int checks = 0;
  int errors = 0;

  // model state
  bit       e_int, e_isr, e_vv;
  bit [7:0] e_irq, e_vec, e_eoi;
  int       e_rot;
  bit       m_ack, m_spur, m_raeoi;
  int       m_lvl;

  interrupt_ack_control dut (
    .clk            (clk),
    .reset          (reset),
    .highestRequest (highestRequest),
    .highestInServ  (highestInServ),
    .inta           (inta),
    .ocw2Strobe     (ocw2Strobe),
    .ocw2Cmd        (ocw2Cmd),
    .ocw2Level      (ocw2Level),
    .autoEoi        (autoEoi),
    .vectorBase     (vectorBase),
    .intOut         (intOut),
    .inServSignal   (inServSignal),
    .interrupt      (interrupt),
    .vectorOut      (vectorOut),
    .vectorValid    (vectorValid),
    .endOfInterrupt (endOfInterrupt),
    .priorityRotate (priorityRotate)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rank(input int l, input int rot);
    return (l - rot - 1 + 16) % 8;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: predict, clock, compare every output
  task automatic cyc();
    bit       n_int, n_isr, n_vv, n_ack, n_spur, n_raeoi;
    bit [7:0] n_irq, n_vec, n_eoi;
    int       n_rot, n_lvl, ri, si, ol;
    if (reset) begin
      n_int = 0; n_isr = 0; n_vv = 0; n_irq = 0; n_vec = 0;
      n_eoi = 0; n_rot = 7; n_raeoi = 0; n_ack = 0; n_spur = 0;
      n_lvl = 0;
    end else begin
      n_int = 0; n_isr = 0; n_vv = 0; n_irq = 0; n_eoi = 0;
      n_vec = e_vec; n_rot = e_rot; n_raeoi = m_raeoi;
      n_ack = m_ack; n_spur = m_spur; n_lvl = m_lvl;
      ri = idx(highestRequest);
      si = idx(highestInServ);
      ol = int'(ocw2Level);
      if (!m_ack) begin
        if (inta) begin
          n_ack  = 1;
          n_spur = (ri < 0);
          n_lvl  = (ri < 0) ? 7 : ri;
          if (ri >= 0) begin
            n_isr = 1;
            n_irq = 8'(1 << ri);
          end
        end else begin
          n_int = (ri >= 0) &&
                  (si < 0 || rank(ri, e_rot) < rank(si, e_rot));
        end
      end else if (inta) begin
        n_ack = 0;
        n_vv  = 1;
        n_vec = {vectorBase, 3'(m_lvl)};
        if (autoEoi && !m_spur) begin
          n_eoi = 8'(1 << m_lvl);
          if (m_raeoi) n_rot = m_lvl;
        end
      end
      if (ocw2Strobe) begin
        case (ocw2Cmd)
          3'd1: if (si >= 0) n_eoi |= 8'(1 << si);
          3'd3: n_eoi |= 8'(1 << ol);
          3'd5: if (si >= 0) begin
            n_eoi |= 8'(1 << si);
            n_rot = si;
          end
          3'd7: begin
            n_eoi |= 8'(1 << ol);
            n_rot = ol;
          end
          3'd6: n_rot = ol;
          3'd4: n_raeoi = 1;
          3'd0: n_raeoi = 0;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    e_int = n_int; e_isr = n_isr; e_vv = n_vv; e_irq = n_irq;
    e_vec = n_vec; e_eoi = n_eoi; e_rot = n_rot;
    m_ack = n_ack; m_spur = n_spur; m_raeoi = n_raeoi;
    m_lvl = n_lvl;
    chk("intOut", {7'd0, intOut}, {7'd0, e_int});
    chk("inServSignal", {7'd0, inServSignal}, {7'd0, e_isr});
    chk("interrupt", interrupt, e_irq);
    chk("vectorOut", vectorOut, e_vec);
    chk("vectorValid", {7'd0, vectorValid}, {7'd0, e_vv});
    chk("endOfInterrupt", endOfInterrupt, e_eoi);
    chk("priorityRotate", {5'd0, priorityRotate}, 8'(e_rot));
  endtask

  task automatic ocw(input logic [2:0] c, input logic [2:0] l);
    ocw2Strobe = 1; ocw2Cmd = c; ocw2Level = l;
    cyc();
    ocw2Strobe = 0;
  endtask

  initial begin
    int r;
    reset = 1; highestRequest = 0; highestInServ = 0; inta = 0;
    ocw2Strobe = 0; ocw2Cmd = 0; ocw2Level = 0; autoEoi = 0;
    vectorBase = 0;
    e_int = 0; e_isr = 0; e_vv = 0; e_irq = 0; e_vec = 0; e_eoi = 0;
    e_rot = 7; m_ack = 0; m_spur = 0; m_raeoi = 0; m_lvl = 0;
    cyc();
    cyc();
    chk("rst_int", {7'd0, intOut}, 8'd0);
    chk("rst_rot", {5'd0, priorityRotate}, 8'd7);
    reset = 0;

    // basic acknowledge of IR3
    highestRequest = 8'h08; vectorBase = 5'h11;
    cyc();
    chk("basic_int", {7'd0, intOut}, 8'd1);
    inta = 1; cyc(); inta = 0;
    chk("basic_isr", {7'd0, inServSignal}, 8'd1);
    chk("basic_irq", interrupt, 8'h08);
    highestInServ = 8'h08; highestRequest = 0;
    cyc();
    inta = 1; cyc(); inta = 0;
    chk("basic_vec", vectorOut, 8'h8B);
    chk("basic_vv", {7'd0, vectorValid}, 8'd1);
    cyc();

    // nesting against IR2 in service
    highestInServ = 8'h04; highestRequest = 8'h10;
    cyc(); cyc();
    chk("nest_blocked", {7'd0, intOut}, 8'd0);
    highestRequest = 8'h02;
    cyc();
    chk("nest_higher", {7'd0, intOut}, 8'd1);
    inta = 1; cyc(); inta = 0; cyc();
    inta = 1; cyc(); inta = 0;
    highestRequest = 0; highestInServ = 0;
    cyc();

    // spurious acknowledge
    highestRequest = 8'h04;
    cyc();
    highestRequest = 0; inta = 1;
    cyc(); inta = 0;
    chk("spur_isr", {7'd0, inServSignal}, 8'd0);
    cyc();
    inta = 1; cyc(); inta = 0;
    chk("spur_vec", vectorOut, 8'h8F);
    cyc();

    // rotate on non-specific EOI
    highestInServ = 8'h20;
    ocw(3'b101, 3'd0);
    chk("rnseoi_eoi", endOfInterrupt, 8'h20);
    chk("rnseoi_rot", {5'd0, priorityRotate}, 8'd5);
    highestInServ = 8'h01; highestRequest = 8'h40;
    cyc(); cyc();
    chk("rot_ir6_over_ir0", {7'd0, intOut}, 8'd1);
    highestInServ = 8'h40; highestRequest = 8'h01;
    cyc(); cyc();
    chk("rot_ir0_below_ir6", {7'd0, intOut}, 8'd0);
    highestInServ = 0; highestRequest = 0;
    cyc();

    // AEOI with rotation
    autoEoi = 1;
    ocw(3'b100, 3'd0);
    highestRequest = 8'h08;
    cyc();
    inta = 1; cyc(); inta = 0; cyc();
    inta = 1; cyc(); inta = 0;
    chk("aeoi_eoi", endOfInterrupt, 8'h08);
    chk("aeoi_vv", {7'd0, vectorValid}, 8'd1);
    chk("aeoi_rot", {5'd0, priorityRotate}, 8'd3);
    highestRequest = 0; autoEoi = 0;
    ocw(3'b000, 3'd0);

    // edge commands
    highestInServ = 0;
    ocw(3'b001, 3'd0);
    chk("empty_eoi", endOfInterrupt, 8'h00);
    ocw(3'b110, 3'd2);
    chk("setprio_rot", {5'd0, priorityRotate}, 8'd2);
    ocw(3'b011, 3'd6);
    chk("spec_eoi", endOfInterrupt, 8'h40);

    // reset in ACK1, then a fresh acknowledge
    highestRequest = 8'h02;
    cyc();
    inta = 1; cyc(); inta = 0;
    reset = 1; cyc(); reset = 0;
    chk("rst_ack1_int", {7'd0, intOut}, 8'd0);
    chk("rst_ack1_vv", {7'd0, vectorValid}, 8'd0);
    chk("rst_ack1_vec", vectorOut, 8'h00);
    chk("rst_ack1_rot", {5'd0, priorityRotate}, 8'd7);
    inta = 1; cyc(); inta = 0;
    chk("fresh_isr", {7'd0, inServSignal}, 8'd1);
    cyc();
    inta = 1; cyc(); inta = 0;
    chk("fresh_vv", {7'd0, vectorValid}, 8'd1);
    highestRequest = 0;
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      highestRequest = (r >= 8) ? 8'h00 : 8'(1 << r);
      r = $urandom_range(0, 11);
      highestInServ = (r >= 8) ? 8'h00 : 8'(1 << r);
      inta = ($urandom_range(0, 3) == 0);
      ocw2Strobe = ($urandom_range(0, 5) == 0);
      ocw2Cmd = 3'($urandom_range(0, 7));
      ocw2Level = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) autoEoi = ~autoEoi;
      if ($urandom_range(0, 63) == 0) vectorBase = 5'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 0; inta = 0; ocw2Strobe = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
